// File: rtl/barrel_pkg.sv
// Shared types and constants for the barrel shifter and its de-rotating reader.
package barrel_pkg;
  localparam int WIDTH = 16;
  localparam int AMT_W = 4;
  localparam int HALF  = 8;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ROTATE = 2'd1,
    DONE   = 2'd2
  } state_t;
endpackage

// File: rtl/shift_offset_tracker.sv
// Mod-2^AMT_W left-rotation offset mirrored from the shifter's load/shift controls.
module shift_offset_tracker #(
  parameter int AMT_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic             dir_right_i,
  input  logic [AMT_W-1:0] amount_i,
  output logic [AMT_W-1:0] offset_o
);
  logic [AMT_W-1:0] offset_q, offset_d;

  // Wrap-around arithmetic makes a half-width amount land on the same offset in either direction.
  always_comb begin
    offset_d = offset_q;
    if (load_i)                 offset_d = '0;
    else if (amount_i == '0)    offset_d = offset_q;
    else if (dir_right_i)       offset_d = offset_q - amount_i;
    else                        offset_d = offset_q + amount_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) offset_q <= '0;
    else          offset_q <= offset_d;
  end

  assign offset_o = offset_q;
endmodule

// File: rtl/barrel_unshift_reader.sv
// Captures the shifter's word on request and rotates it back one bit per cycle,
// choosing the shorter direction, then holds the result under valid/ready.
module barrel_unshift_reader #(
  parameter int WIDTH = barrel_pkg::WIDTH,
  parameter int AMT_W = barrel_pkg::AMT_W
) (
  input  logic             i_clk,
  input  logic             i_res_n,
  input  logic             i_load,
  input  logic             i_direction_right,
  input  logic [AMT_W-1:0] i_shift_amount,
  input  logic [WIDTH-1:0] i_word,
  input  logic             i_req,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_word,
  output logic             o_valid,
  output logic             o_busy,
  output logic [AMT_W-1:0] o_offset
);
  import barrel_pkg::*;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [AMT_W-1:0] count_q, count_d;
  logic             dir_q, dir_d;
  logic [AMT_W-1:0] offset;
  logic [AMT_W-1:0] snap_n;
  logic             snap_dir;

  shift_offset_tracker #(.AMT_W(AMT_W)) u_tracker (
    .clk_i       (i_clk),
    .rst_n_i     (i_res_n),
    .load_i      (i_load),
    .dir_right_i (i_direction_right),
    .amount_i    (i_shift_amount),
    .offset_o    (offset)
  );

  // Offsets past half-width are cheaper to undo by rotating left by the complement.
  always_comb begin
    snap_dir = (offset <= AMT_W'(WIDTH / 2)) ? DIR_RIGHT : DIR_LEFT;
    snap_n   = (snap_dir == DIR_RIGHT) ? offset : (AMT_W'(0) - offset);
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    count_d = count_q;
    dir_d   = dir_q;
    case (state_q)
      IDLE: begin
        if (i_req) begin
          work_d  = i_word;
          dir_d   = snap_dir;
          count_d = snap_n;
          state_d = (snap_n == '0) ? DONE : ROTATE;
        end
      end
      ROTATE: begin
        if (dir_q == DIR_RIGHT) work_d = {work_q[0], work_q[WIDTH-1:1]};
        else                    work_d = {work_q[WIDTH-2:0], work_q[WIDTH-1]};
        count_d = count_q - 1'b1;
        if (count_q == AMT_W'(1)) state_d = DONE;
      end
      DONE: begin
        if (i_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_res_n) begin
    if (!i_res_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      count_q <= '0;
      dir_q   <= DIR_RIGHT;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      count_q <= count_d;
      dir_q   <= dir_d;
    end
  end

  assign o_word   = work_q;
  assign o_valid  = (state_q == DONE);
  assign o_busy   = (state_q != IDLE);
  assign o_offset = offset;
endmodule

// File: tb/tb_barrel_unshift_reader.sv
// Directed bench: stimulus pushes expected words, a negedge monitor pops them on each accepted result.
module tb_barrel_unshift_reader;
  logic        i_clk = 1'b0;
  logic        i_res_n = 1'b0;
  logic        i_load = 1'b0;
  logic        i_direction_right = 1'b0;
  logic [3:0]  i_shift_amount = '0;
  logic [15:0] i_word = '0;
  logic        i_req = 1'b0;
  logic        i_ready = 1'b0;
  logic [15:0] o_word;
  logic        o_valid;
  logic        o_busy;
  logic [3:0]  o_offset;

  int checks = 0;
  int failures = 0;
  logic [15:0] sb_q[$];

  barrel_unshift_reader dut (
    .i_clk             (i_clk),
    .i_res_n           (i_res_n),
    .i_load            (i_load),
    .i_direction_right (i_direction_right),
    .i_shift_amount    (i_shift_amount),
    .i_word            (i_word),
    .i_req             (i_req),
    .i_ready           (i_ready),
    .o_word            (o_word),
    .o_valid           (o_valid),
    .o_busy            (o_busy),
    .o_offset          (o_offset)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  always @(negedge i_clk) begin
    if (i_res_n && o_valid && i_ready) begin
      if (sb_q.size() == 0) chk("unexpected_result", 32'(o_word), 32'hDEAD_BEEF);
      else chk("sb_word", 32'(o_word), 32'(sb_q.pop_front()));
    end
  end

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset;
    i_res_n = 1'b0;
    #1;
    chk("rst_valid", 32'(o_valid), 0);
    chk("rst_busy", 32'(o_busy), 0);
    chk("rst_offset", 32'(o_offset), 0);
    chk("rst_word", 32'(o_word), 0);
    tick;
    i_res_n = 1'b1;
  endtask

  task automatic step(input logic ld, input logic rt, input logic [3:0] amt, input logic [3:0] exp_off);
    i_load = ld;
    i_direction_right = rt;
    i_shift_amount = amt;
    tick;
    i_load = 1'b0;
    i_shift_amount = '0;
    chk("offset", 32'(o_offset), 32'(exp_off));
  endtask

  task automatic issue(input logic [15:0] w, input logic [15:0] exp_w, input int n, input bit poke);
    int lat;
    sb_q.push_back(exp_w);
    i_word = w;
    i_req = 1'b1;
    tick;
    i_req = 1'b0;
    lat = 0;
    while (!o_valid && lat < 20) begin
      chk("busy_in_rotate", 32'(o_busy), 1);
      i_req = poke && (lat == 1);
      tick;
      lat++;
    end
    i_req = 1'b0;
    chk("latency", 32'(lat), 32'(n));
    chk("word_at_valid", 32'(o_word), 32'(exp_w));
  endtask

  task automatic accept;
    i_ready = 1'b1;
    tick;
    i_ready = 1'b0;
    chk("valid_after_accept", 32'(o_valid), 0);
    chk("busy_after_accept", 32'(o_busy), 0);
  endtask

  initial begin
    // Left 3 from 0x00A5, undone by 3 right rotations.
    do_reset;
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd3, 4'd3);
    issue(16'h0528, 16'h00A5, 3, 1'b0);
    accept;

    // Right 4 leaves offset 12; undone by 4 left rotations.
    do_reset;
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b1, 4'd4, 4'd12);
    issue(16'h500A, 16'h00A5, 4, 1'b0);
    accept;

    // Tracker sequence; load beats a simultaneous shift.
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd5, 4'd5);
    step(1'b0, 1'b1, 4'd2, 4'd3);
    step(1'b0, 1'b1, 4'd0, 4'd3);
    step(1'b0, 1'b1, 4'd8, 4'd11);
    step(1'b1, 1'b0, 4'd7, 4'd0);

    // Zero offset: result next cycle, held stable under back-pressure.
    issue(16'h1234, 16'h1234, 0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      tick;
      chk("stall_valid", 32'(o_valid), 1);
      chk("stall_word", 32'(o_word), 32'h1234);
    end
    accept;

    // Offset 8: eight right rotations; a request mid-rotate is dropped.
    step(1'b0, 1'b0, 4'd8, 4'd8);
    issue(16'hA500, 16'h00A5, 8, 1'b1);
    accept;
    for (int i = 0; i < 4; i++) tick;
    chk("no_second_result", 32'(o_valid), 0);
    chk("word_held_idle", 32'(o_word), 32'h00A5);

    // Reset in the second rotate cycle, then a normal request.
    step(1'b1, 1'b0, 4'd0, 4'd0);
    step(1'b0, 1'b0, 4'd2, 4'd2);
    i_word = 16'h0004;
    i_req = 1'b1;
    tick;
    i_req = 1'b0;
    tick;
    chk("pre_reset_busy", 32'(o_busy), 1);
    do_reset;
    step(1'b0, 1'b0, 4'd1, 4'd1);
    issue(16'h0002, 16'h0001, 1, 1'b0);
    accept;

    tick;
    chk("scoreboard_empty", 32'(sb_q.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
